// File: rtl/cr_prefix_pf_buf_pkg.sv
// Shared prefix-path package: buffer sizing, debug status layout and a
// saturating increment helper used by the drop counter.
package cr_prefixPKG;

  localparam int N_PREFIX_PF_ENTRIES = 16;
  localparam int PREFIX_PF_AFULL     = 12;
  localparam int PREFIX_PF_WIDTH     = 9;
  localparam int PREFIX_PF_LVL_W     = $clog2(N_PREFIX_PF_ENTRIES + 1);

  // Folded into the debug status registers.
  typedef struct packed {
    logic                       ovfl;
    logic [15:0]                drop_cnt;
    logic [PREFIX_PF_LVL_W-1:0] level;
  } prefix_pf_status_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cr_prefix_pf_buf_stat.sv
// Debug status for the prefix buffer: sticky overflow flag and a 16-bit
// saturating count of dropped writes.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_drop        : a write was dropped this cycle
//   i_clr         : clear both status fields (a same-cycle drop still counts)
//   o_ovfl        : sticky overflow flag
//   o_drop_cnt    : dropped-write count, saturates at 0xFFFF
module cr_prefix_pf_stat
  import cr_prefixPKG::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_drop,
  input  logic        i_clr,
  output logic        o_ovfl,
  output logic [15:0] o_drop_cnt
);

  logic        r_ovfl;
  logic [15:0] r_drop_cnt;
  logic        w_ovfl_nxt;
  logic [15:0] w_drop_cnt_nxt;

  // Clear first, then the drop lands on the cleared value.
  always_comb begin
    w_ovfl_nxt     = r_ovfl;
    w_drop_cnt_nxt = r_drop_cnt;
    if (i_clr) begin
      w_ovfl_nxt     = 1'b0;
      w_drop_cnt_nxt = 16'd0;
    end
    if (i_drop) begin
      w_ovfl_nxt     = 1'b1;
      w_drop_cnt_nxt = sat_inc16(w_drop_cnt_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovfl     <= 1'b0;
      r_drop_cnt <= 16'd0;
    end else begin
      r_ovfl     <= w_ovfl_nxt;
      r_drop_cnt <= w_drop_cnt_nxt;
    end
  end

  assign o_ovfl     = r_ovfl;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: rtl/cr_prefix_pf_buf.sv
// Prefix output buffer between the recognizer microsequencer and the prefix
// consumer. First-word-fall-through FIFO with registered full/almost-full
// back-pressure and debug drop statistics.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   rec_us_prefix_valid     : write strobe from the recognizer
//   rec_us_pf_datain        : prefix word to write
//   pf_full, pf_afull       : back-pressure, decoded from registered level
//   pf_ob_valid, pf_ob_data : head word presented to the consumer
//   pf_ob_rd                : consumer pop (ignored when empty)
//   pf_level                : current occupancy
//   pf_ovfl, pf_drop_cnt    : debug status
//   pf_clr_stat             : clear debug status
module cr_prefix_pf_buf
  import cr_prefixPKG::*;
#(
  parameter int DEPTH        = N_PREFIX_PF_ENTRIES,
  parameter int AFULL_THRESH = PREFIX_PF_AFULL,
  parameter int WIDTH        = PREFIX_PF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rec_us_prefix_valid,
  input  logic [WIDTH-1:0]           rec_us_pf_datain,
  output logic                       pf_full,
  output logic                       pf_afull,
  output logic                       pf_ob_valid,
  output logic [WIDTH-1:0]           pf_ob_data,
  input  logic                       pf_ob_rd,
  output logic [$clog2(DEPTH+1)-1:0] pf_level,
  output logic                       pf_ovfl,
  output logic [15:0]                pf_drop_cnt,
  input  logic                       pf_clr_stat
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  logic w_full;
  logic w_valid;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_drop;

  assign w_full   = (r_level == LW'(DEPTH));
  assign w_valid  = (r_level != '0);
  // Acceptance uses the registered full flag, so a same-cycle pop never
  // frees a slot for the write.
  assign w_wr_acc = rec_us_prefix_valid & ~w_full;
  assign w_rd_acc = pf_ob_rd & w_valid;
  assign w_drop   = rec_us_prefix_valid & w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= rec_us_pf_datain;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  cr_prefix_pf_stat u_stat (
    .clk        (clk),
    .rst        (rst),
    .i_drop     (w_drop),
    .i_clr      (pf_clr_stat),
    .o_ovfl     (pf_ovfl),
    .o_drop_cnt (pf_drop_cnt)
  );

  assign pf_full     = w_full;
  assign pf_afull    = (r_level >= LW'(AFULL_THRESH));
  assign pf_ob_valid = w_valid;
  assign pf_ob_data  = r_mem[r_rd_ptr];
  assign pf_level    = r_level;

endmodule

// File: tb/tb_cr_prefix_pf_buf.sv
module tb_cr_prefix_pf_buf;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_v = 1'b0;
  logic [8:0] wr_d = '0;
  logic       rd = 1'b0;
  logic       clr = 1'b0;
  logic       full, afull, ob_valid, ovfl;
  logic [8:0] ob_data;
  logic [4:0] level;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b1;

  // Reference model: queue of words plus status
  logic [8:0] q[$];
  bit m_ovfl;
  int m_cnt;

  always #5 clk = ~clk;

  cr_prefix_pf_buf dut (
    .clk                 (clk),
    .rst                 (rst),
    .rec_us_prefix_valid (wr_v),
    .rec_us_pf_datain    (wr_d),
    .pf_full             (full),
    .pf_afull            (afull),
    .pf_ob_valid         (ob_valid),
    .pf_ob_data          (ob_data),
    .pf_ob_rd            (rd),
    .pf_level            (level),
    .pf_ovfl             (ovfl),
    .pf_drop_cnt         (drop_cnt),
    .pf_clr_stat         (clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [8:0] d,
                            input bit p, input bit c);
    int sz;
    if (r) begin
      q.delete();
      m_ovfl = 0;
      m_cnt  = 0;
      return;
    end
    sz = q.size();
    if (c) begin
      m_ovfl = 0;
      m_cnt  = 0;
    end
    if (v && sz == DEPTH) begin
      m_ovfl = 1;
      if (m_cnt < 65535) m_cnt++;
    end
    if (p && sz > 0) void'(q.pop_front());
    if (v && sz < DEPTH) q.push_back(d);
  endtask

  task automatic model_check();
    int sz;
    sz = q.size();
    chk("level", level, sz);
    chk("valid", ob_valid, sz != 0);
    chk("full", full, sz == DEPTH);
    chk("afull", afull, sz >= AF);
    chk("ovfl", ovfl, m_ovfl);
    chk("drop_cnt", drop_cnt, m_cnt);
    if (sz != 0) chk("data", ob_data, q[0]);
  endtask

  task automatic cycle(input bit r, input bit v, input logic [8:0] d,
                       input bit p, input bit c);
    rst = r; wr_v = v; wr_d = d; rd = p; clr = c;
    model_step(r, v, d, p, c);
    @(posedge clk);
    #1;
    rst = 0; wr_v = 0; rd = 0; clr = 0;
    if (chk_en) model_check();
  endtask

  typedef struct {
    bit rst, v; logic [8:0] d; bit rd, clr;
    int lvl; bit vld; logic [8:0] dat; bit full, afull, ovfl; int cnt;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{1, 0, 9'h000, 0, 0,  0, 0, 9'h000, 0, 0, 0, 0};
    vt[1] = '{0, 1, 9'h011, 0, 0,  1, 1, 9'h011, 0, 0, 0, 0};
    vt[2] = '{0, 1, 9'h022, 0, 0,  2, 1, 9'h011, 0, 0, 0, 0};
    vt[3] = '{0, 1, 9'h033, 1, 0,  2, 1, 9'h022, 0, 0, 0, 0};
    vt[4] = '{0, 0, 9'h000, 1, 0,  1, 1, 9'h033, 0, 0, 0, 0};
    vt[5] = '{0, 0, 9'h000, 1, 0,  0, 0, 9'h000, 0, 0, 0, 0};
    vt[6] = '{0, 1, 9'h055, 1, 0,  1, 1, 9'h055, 0, 0, 0, 0};
    vt[7] = '{0, 0, 9'h000, 0, 1,  1, 1, 9'h055, 0, 0, 0, 0};

    @(negedge clk);
    // Table-driven vectors from reset
    foreach (vt[i]) begin
      cycle(vt[i].rst, vt[i].v, vt[i].d, vt[i].rd, vt[i].clr);
      chk("tbl_level", level, vt[i].lvl);
      chk("tbl_valid", ob_valid, vt[i].vld);
      chk("tbl_data", ob_data, vt[i].dat);
      chk("tbl_full", full, vt[i].full);
      chk("tbl_afull", afull, vt[i].afull);
      chk("tbl_ovfl", ovfl, vt[i].ovfl);
      chk("tbl_cnt", drop_cnt, vt[i].cnt);
    end

    // Fill then drain
    cycle(1, 0, 0, 0, 0);
    chk("rst_data", ob_data, 0);
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(0, 1, 9'(i), 0, 0);
      chk("fill_afull", afull, i >= AF);
      chk("fill_full", full, i == DEPTH);
    end

    // Overflow while full, then clear
    for (int i = 0; i < 3; i++) cycle(0, 1, 9'h1FF, 0, 0);
    chk("ovf_cnt", drop_cnt, 3);
    chk("ovf_flag", ovfl, 1);
    chk("ovf_head", ob_data, 9'h001);
    cycle(0, 0, 0, 0, 1);
    chk("clr_cnt", drop_cnt, 0);
    chk("clr_flag", ovfl, 0);

    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_data", ob_data, 9'(i));
      cycle(0, 0, 0, 1, 0);
      chk("drain_valid", ob_valid, i < DEPTH);
    end

    // Simultaneous pop and write at full and at empty
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 9'(i + 32), 0, 0);
    cycle(0, 1, 9'h0AA, 1, 0);
    chk("popwr_full_lvl", level, 15);
    chk("popwr_full_cnt", drop_cnt, 1);
    // Clear and drop together: clear wins then the drop counts
    cycle(0, 1, 9'h0AB, 0, 0);
    cycle(0, 1, 9'h0AC, 0, 1);
    chk("clrdrop_cnt", drop_cnt, 1);
    chk("clrdrop_ovfl", ovfl, 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 1, 0);
    chk("empty_lvl", level, 0);
    cycle(0, 1, 9'h055, 1, 0);
    chk("popwr_empty_data", ob_data, 9'h055);
    chk("popwr_empty_lvl", level, 1);

    // Pointer wrap at steady level 3
    cycle(0, 1, 9'h100, 0, 0);
    cycle(0, 1, 9'h101, 0, 0);
    for (int i = 0; i < 100; i++) cycle(0, 1, 9'(i + 2), 1, 0);
    chk("wrap_lvl", level, 3);

    // Randomized phases biased toward filling, then draining
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 300; i++) begin
        bit v, p, c;
        v = ($urandom_range(0, 3) < ((ph % 2 == 0) ? 3 : 1));
        p = ($urandom_range(0, 3) < ((ph % 2 == 0) ? 1 : 3));
        c = ($urandom_range(0, 15) == 0);
        cycle(0, v, 9'($urandom), p, c);
      end
    end

    // Reset mid-stream with a write in the reset cycle
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 1, 9'(i + 7), 0, 0);
    chk("pre_rst_lvl", level, 7);
    cycle(1, 1, 9'h0EE, 0, 0);
    chk("rst_lvl", level, 0);
    chk("rst_valid", ob_valid, 0);
    chk("rst_cnt", drop_cnt, 0);

    // Drop counter saturation
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 9'(i), 0, 0);
    chk_en = 0;
    for (int i = 0; i < 65540; i++) cycle(0, 1, 9'h1FF, 0, 0);
    chk_en = 1;
    chk("sat_cnt", drop_cnt, 16'hFFFF);
    chk("sat_ovfl", ovfl, 1);
    cycle(0, 1, 9'h1FF, 0, 0);
    chk("sat_hold", drop_cnt, 16'hFFFF);
    chk("sat_head", ob_data, 9'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr_prefix_pf_buf.md
# cr_prefix_pf_buf

Output prefix buffer placed directly downstream of the prefix recognizer's microsequencer. It absorbs the 9-bit prefix words the recognizer emits and returns the `pf_full`/`pf_afull` back-pressure the sequencer uses to hold. It presents a first-word-fall-through interface to the prefix consumer. It also keeps a sticky overflow flag and a saturating drop counter for debug status.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; power of two, at least 4.
- `AFULL_THRESH`, 12: `pf_afull` asserts when level ≥ this value; must satisfy 1 ≤ value ≤ `DEPTH`.
- `WIDTH`, 9: prefix word width.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `rec_us_prefix_valid`, in, 1: write strobe from the recognizer.
- `rec_us_pf_datain`, in, `WIDTH`: prefix word to write.
- `pf_full`, out, 1: level == `DEPTH`.
- `pf_afull`, out, 1: level ≥ `AFULL_THRESH`.
- `pf_ob_valid`, out, 1: head word present.
- `pf_ob_data`, out, `WIDTH`: head word.
- `pf_ob_rd`, in, 1: consumer pop; ignored while `pf_ob_valid` = 0.
- `pf_level`, out, clog2(`DEPTH`+1): current occupancy.
- `pf_ovfl`, out, 1: sticky; set on a dropped write.
- `pf_drop_cnt`, out, 16: count of dropped writes, saturates at 0xFFFF.
- `pf_clr_stat`, in, 1: clears `pf_ovfl` and `pf_drop_cnt`.

## Operation
- Storage is a flop array with `rd_ptr`/`wr_ptr` of width log2(`DEPTH`), wrapping naturally, plus a separate level register.
- Write acceptance: `wr_acc` = `rec_us_prefix_valid` & !`pf_full`.
  - `pf_full` is the registered-level flag.
  - A write while full is dropped even if a pop happens in the same cycle.
- Pop: `rd_acc` = `pf_ob_rd` & `pf_ob_valid`.
- Level update:
  - Increments on `wr_acc` only.
  - Decrements on `rd_acc` only.
  - Stays unchanged when both occur.
- Dropped write: sets `pf_ovfl` and increments `pf_drop_cnt` (saturating).
  - Simultaneous `pf_clr_stat` and a drop: clear wins, then the drop applies. Result is `pf_ovfl` = 1 and `pf_drop_cnt` = 1.
- Outputs:
  - `pf_ob_data` = mem[`rd_ptr`].
  - `pf_ob_valid` = (level != 0).
  - `pf_full`, `pf_afull`, and `pf_level` are decoded from the registered level only; they never depend combinationally on inputs.
- Data is not interpreted; words leave in write order, bit-exact.
- Reset values: pointers 0, level 0, `pf_ob_valid` 0, `pf_full` 0, `pf_afull` 0, `pf_level` 0, `pf_ovfl` 0, `pf_drop_cnt` 0, `pf_ob_data` 0 (array cleared).
- Reset asserted mid-stream discards all contents. Input strobes in the reset cycle are ignored and not counted as drops.

## Timing
- Write at cycle N (buffer empty) → `pf_ob_valid` = 1 and data visible at N+1.
- Pop at cycle N → next word, or `pf_ob_valid` = 0, at N+1.
- `pf_full` and `pf_afull` update the cycle after the write or pop that crosses the threshold.
  - The sequencer sees `pf_afull` one cycle late. `DEPTH` − `AFULL_THRESH` ≥ 2 is therefore required for loss-free throttling; the default gives 4 slots of slack.
- Pop and write both at level `DEPTH`: pop accepted, write dropped, level becomes `DEPTH`−1.
- Pop and write both at level 0: pop ignored, write accepted, level becomes 1.
- Sustained one write plus one pop per cycle at a level between 1 and `DEPTH`−1 runs at full throughput with level constant.

## Structure
- Add `N_PREFIX_PF_ENTRIES` (16) and `PREFIX_PF_AFULL` (12) to `cr_prefixPKG`; the top level instantiates with these values.
- Add a `prefix_pf_status_t` struct (`ovfl`, `drop_cnt`, `level`) to the shared package so it can be folded into the debug status registers.
- One sub-module, `cr_prefix_pf_stat`: holds the sticky overflow flag and the saturating drop counter. The storage, pointers and level stay in the parent.

## Test plan
- **Fill then drain.** After reset, write 0x001…0x010 on consecutive cycles with `pf_ob_rd` = 0.
  - `pf_afull` rises the cycle after the 12th write; `pf_full` rises after the 16th.
  - Draining returns 0x001…0x010 in order; `pf_ob_valid` falls after the 16th pop.
- **Overflow while full.** With the buffer full, write 0x1FF for 3 cycles → contents unchanged, `pf_ovfl` = 1, `pf_drop_cnt` = 3. Then assert `pf_clr_stat` → both read 0.
- **Simultaneous pop and write.**
  - At level 16 with write 0x0AA: level becomes 15 and 0x0AA is dropped (`pf_drop_cnt` increments).
  - At level 0 with write 0x055: `pf_ob_data` = 0x055 next cycle, level 1.
- **Pointer wrap.** Run 100 cycles of write+pop at level 3 with an incrementing pattern → no data loss or reordering, level stays 3.
- **Reset mid-stream.** At level 7, assert `rst` together with a write → next cycle level 0, `pf_ob_valid` 0, `pf_drop_cnt` 0.
- **Saturation.** Force 65,540 dropped writes → `pf_drop_cnt` holds at 0xFFFF.
